// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: four-requester arbiter for a single RAM data port.
// Grants are bursts of up to BURST_LEN cycles. Every ownership ends with one
// GAP cycle followed by one IDLE cycle, so a handover always costs two dead
// cycles. All outputs are registered.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// without it, fixed priority applies (requester 0 highest).
module ram_port_arbiter #(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] s,
    output logic       ram_en,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(BURST_LEN + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(BURST_LEN);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StOwn,
        StGap
    } state_t;

    state_t          state_q;
    logic [CntW-1:0] cnt_q;

    // Winner of the arbitration, looking only at the current req bits.
    logic       win_valid;
    logic [1:0] win_idx;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] last_q;
    logic [1:0] rr_idx;

    // Round-robin search starting just after the previous owner, wrapping mod 4.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        rr_idx    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            rr_idx = last_q + 2'(i + 1);
            if (!win_valid && req[rr_idx]) begin
                win_valid = 1'b1;
                win_idx   = rr_idx;
            end
        end
    end

    // Remember the last owner; reset value 3 gives requester 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 2'd3;
        end else if (state_q == StIdle && win_valid) begin
            last_q <= win_idx;
        end
    end
`else
    // Fixed priority: lowest-numbered requesting bit wins.
    always_comb begin
        win_valid = |req;
        win_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                win_idx = 2'(i);
            end
        end
    end
`endif

    // Arbiter FSM with registered grant, select, enable and busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            gnt     <= 4'b0000;
            s       <= 2'b00;
            ram_en  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    // s keeps the previous owner while idle.
                    if (win_valid) begin
                        state_q <= StOwn;
                        cnt_q   <= CntOne;
                        gnt     <= 4'b0001 << win_idx;
                        s       <= win_idx;
                        ram_en  <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                StOwn: begin
                    // Only the owner's request bit matters here; s is the owner.
                    if (!req[s] || cnt_q == CntMax) begin
                        state_q <= StGap;
                        cnt_q   <= '0;
                        gnt     <= 4'b0000;
                        ram_en  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StGap: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    gnt     <= 4'b0000;
                    ram_en  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // BURST_LEN outside 1..16 is not a supported configuration.
    if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_burst_len
        $error("ram_port_arbiter: BURST_LEN must be in 1..16");
    end

`ifndef SYNTHESIS
    // Structural invariants of the grant outputs.
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt));
    a_ram_en_or : assert property (@(posedge clk) disable iff (!rst_n)
        ram_en == (|gnt));
    a_busy_state : assert property (@(posedge clk) disable iff (!rst_n)
        busy == (state_q != StIdle));
    a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= CntMax);
    a_s_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (ram_en && $past(ram_en)) |-> $stable(s));
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and model-checked random tests for ram_port_arbiter.
// Expectations follow the fixed-priority build unless ARB_ROUND_ROBIN_EN is set.
module tb_ram_port_arbiter;

    localparam int unsigned BL = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       ram_en;
    logic       busy;

    int checks = 0;
    int passed = 0;

    ram_port_arbiter #(
        .BURST_LEN(BL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .s     (s),
        .ram_en(ram_en),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; sampling and driving happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        #3;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        #2;
        checks++;
        if ({gnt, s, ram_en, busy} !== 8'b0) $display("FAIL reset_value: got %b want %b", {gnt, s, ram_en, busy}, 8'b0);
        else passed++;
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== 8'b0) $display("FAIL reset_held: got %b want %b", {gnt, s, ram_en, busy}, 8'b0);
        else passed++;
        req   = 4'b0000;
        rst_n = 1'b1;
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== 8'b0) $display("FAIL idle_no_req: got %b want %b", {gnt, s, ram_en, busy}, 8'b0);
        else passed++;
    endtask

    task automatic test_first_grant();
        do_reset();
        req = 4'b0100;
        #1;
        checks++;
        if ({gnt, s, ram_en, busy} !== 8'b0) $display("FAIL no_comb_path: got %b want %b", {gnt, s, ram_en, busy}, 8'b0);
        else passed++;
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== {4'b0100, 2'b10, 1'b1, 1'b1}) $display("FAIL first_grant: got %b want %b", {gnt, s, ram_en, busy}, {4'b0100, 2'b10, 1'b1, 1'b1});
        else passed++;
    endtask

    task automatic test_burst();
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < BL; c++) begin
            tick();
            checks++;
            if ({gnt, s, ram_en, busy} !== {4'b0001, 2'b00, 1'b1, 1'b1}) $display("FAIL burst_cycle%0d: got %b want %b", c, {gnt, s, ram_en, busy}, {4'b0001, 2'b00, 1'b1, 1'b1});
            else passed++;
        end
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== {4'b0000, 2'b00, 1'b0, 1'b1}) $display("FAIL burst_gap: got %b want %b", {gnt, s, ram_en, busy}, {4'b0000, 2'b00, 1'b0, 1'b1});
        else passed++;
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== {4'b0000, 2'b00, 1'b0, 1'b0}) $display("FAIL burst_idle: got %b want %b", {gnt, s, ram_en, busy}, {4'b0000, 2'b00, 1'b0, 1'b0});
        else passed++;
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== {4'b0001, 2'b00, 1'b1, 1'b1}) $display("FAIL burst_regrant: got %b want %b", {gnt, s, ram_en, busy}, {4'b0001, 2'b00, 1'b1, 1'b1});
        else passed++;
    endtask

    task automatic test_all_requests();
        logic [1:0] own;
        logic [3:0] g;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            own = 2'(k % 4);
`else
            own = 2'd0;
`endif
            g = 4'b0001 << own;
            for (int c = 0; c < BL; c++) begin
                tick();
                checks++;
                if ({gnt, s, ram_en, busy} !== {g, own, 1'b1, 1'b1}) $display("FAIL all_req_own%0d_c%0d: got %b want %b", k, c, {gnt, s, ram_en, busy}, {g, own, 1'b1, 1'b1});
                else passed++;
            end
            tick();
            checks++;
            if ({gnt, s, ram_en, busy} !== {4'b0000, own, 1'b0, 1'b1}) $display("FAIL all_req_gap%0d: got %b want %b", k, {gnt, s, ram_en, busy}, {4'b0000, own, 1'b0, 1'b1});
            else passed++;
            tick();
            checks++;
            if ({gnt, s, ram_en, busy} !== {4'b0000, own, 1'b0, 1'b0}) $display("FAIL all_req_idle%0d: got %b want %b", k, {gnt, s, ram_en, busy}, {4'b0000, own, 1'b0, 1'b0});
            else passed++;
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req = 4'b0100;
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== {4'b0100, 2'b10, 1'b1, 1'b1}) $display("FAIL early_own1: got %b want %b", {gnt, s, ram_en, busy}, {4'b0100, 2'b10, 1'b1, 1'b1});
        else passed++;
        req = 4'b1100;
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== {4'b0100, 2'b10, 1'b1, 1'b1}) $display("FAIL early_own2: got %b want %b", {gnt, s, ram_en, busy}, {4'b0100, 2'b10, 1'b1, 1'b1});
        else passed++;
        req = 4'b1000;
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== {4'b0000, 2'b10, 1'b0, 1'b1}) $display("FAIL early_gap: got %b want %b", {gnt, s, ram_en, busy}, {4'b0000, 2'b10, 1'b0, 1'b1});
        else passed++;
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== {4'b0000, 2'b10, 1'b0, 1'b0}) $display("FAIL early_idle: got %b want %b", {gnt, s, ram_en, busy}, {4'b0000, 2'b10, 1'b0, 1'b0});
        else passed++;
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== {4'b1000, 2'b11, 1'b1, 1'b1}) $display("FAIL early_handover: got %b want %b", {gnt, s, ram_en, busy}, {4'b1000, 2'b11, 1'b1, 1'b1});
        else passed++;
    endtask

    task automatic test_nonowner_change();
        logic [7:0] next_exp;
        do_reset();
        req = 4'b0010;
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== {4'b0010, 2'b01, 1'b1, 1'b1}) $display("FAIL nonowner_grant: got %b want %b", {gnt, s, ram_en, busy}, {4'b0010, 2'b01, 1'b1, 1'b1});
        else passed++;
        req = 4'b1011;
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== {4'b0010, 2'b01, 1'b1, 1'b1}) $display("FAIL nonowner_c2: got %b want %b", {gnt, s, ram_en, busy}, {4'b0010, 2'b01, 1'b1, 1'b1});
        else passed++;
        req = 4'b0111;
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== {4'b0010, 2'b01, 1'b1, 1'b1}) $display("FAIL nonowner_c3: got %b want %b", {gnt, s, ram_en, busy}, {4'b0010, 2'b01, 1'b1, 1'b1});
        else passed++;
        req = 4'b1111;
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== {4'b0010, 2'b01, 1'b1, 1'b1}) $display("FAIL nonowner_c4: got %b want %b", {gnt, s, ram_en, busy}, {4'b0010, 2'b01, 1'b1, 1'b1});
        else passed++;
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== {4'b0000, 2'b01, 1'b0, 1'b1}) $display("FAIL nonowner_limit_gap: got %b want %b", {gnt, s, ram_en, busy}, {4'b0000, 2'b01, 1'b0, 1'b1});
        else passed++;
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== {4'b0000, 2'b01, 1'b0, 1'b0}) $display("FAIL nonowner_idle: got %b want %b", {gnt, s, ram_en, busy}, {4'b0000, 2'b01, 1'b0, 1'b0});
        else passed++;
`ifdef ARB_ROUND_ROBIN_EN
        next_exp = {4'b0100, 2'b10, 1'b1, 1'b1};
`else
        next_exp = {4'b0001, 2'b00, 1'b1, 1'b1};
`endif
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== next_exp) $display("FAIL nonowner_rearb: got %b want %b", {gnt, s, ram_en, busy}, next_exp);
        else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0010;
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== {4'b0010, 2'b01, 1'b1, 1'b1}) $display("FAIL areset_pre: got %b want %b", {gnt, s, ram_en, busy}, {4'b0010, 2'b01, 1'b1, 1'b1});
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, s, ram_en, busy} !== 8'b0) $display("FAIL areset_immediate: got %b want %b", {gnt, s, ram_en, busy}, 8'b0);
        else passed++;
        req = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== 8'b0) $display("FAIL areset_idle_after: got %b want %b", {gnt, s, ram_en, busy}, 8'b0);
        else passed++;
        req = 4'b0010;
        tick();
        checks++;
        if ({gnt, s, ram_en, busy} !== {4'b0010, 2'b01, 1'b1, 1'b1}) $display("FAIL areset_first_arb: got %b want %b", {gnt, s, ram_en, busy}, {4'b0010, 2'b01, 1'b1, 1'b1});
        else passed++;
    endtask

    task automatic test_random();
        int         m_state;  // 0 idle, 1 own, 2 gap
        int         m_cnt;
        int         run;
        logic [1:0] m_own;
        logic [1:0] m_ptr;
        logic [1:0] w;
        logic [1:0] prev_s;
        logic       prev_en;
        logic       found;
        logic [7:0] exp_v;
        do_reset();
        m_state = 0;
        m_cnt   = 0;
        run     = 0;
        m_own   = 2'd0;
        m_ptr   = 2'd3;
        prev_s  = 2'd0;
        prev_en = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            case (m_state)
                0: begin
                    if (req != 4'b0000) begin
                        w     = 2'd0;
                        found = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                        for (int i = 1; i <= 4; i++) begin
                            if (!found && req[(int'(m_ptr) + i) % 4]) begin
                                found = 1'b1;
                                w     = 2'((int'(m_ptr) + i) % 4);
                            end
                        end
`else
                        for (int i = 0; i < 4; i++) begin
                            if (!found && req[i]) begin
                                found = 1'b1;
                                w     = 2'(i);
                            end
                        end
`endif
                        m_state = 1;
                        m_cnt   = 1;
                        m_own   = w;
                        m_ptr   = w;
                    end
                end
                1: begin
                    if (!req[m_own] || m_cnt == BL) m_state = 2;
                    else m_cnt++;
                end
                default: m_state = 0;
            endcase
            tick();
            exp_v = {(m_state == 1) ? (4'b0001 << m_own) : 4'b0000, m_own, m_state == 1, m_state != 0};
            checks++;
            if ({gnt, s, ram_en, busy} !== exp_v) $display("FAIL random_model n=%0d req=%b: got %b want %b", n, req, {gnt, s, ram_en, busy}, exp_v);
            else passed++;
            checks++;
            if (!$onehot0(gnt)) $display("FAIL random_onehot n=%0d: got %b want at most one bit", n, gnt);
            else passed++;
            checks++;
            if (ram_en && prev_en && s !== prev_s) $display("FAIL random_s_stable n=%0d: got %b want %b", n, s, prev_s);
            else passed++;
            run = ram_en ? run + 1 : 0;
            checks++;
            if (run > BL) $display("FAIL random_burst_len n=%0d: got %0d want <= %0d", n, run, BL);
            else passed++;
            prev_s  = s;
            prev_en = ram_en;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        test_reset();
        test_first_grant();
        test_burst();
        test_all_requests();
        test_early_release();
        test_nonowner_change();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
